// File: rtl/simon_iterative_core_pkg.sv
// Shared definitions for the iterative Simon engine.
// Holds the five 62-bit z constant sequences, width-generic rotate helpers
// (operands carried in 64 bits and masked to the active word size), the Simon
// round function and the control-FSM state encoding.
package simon_iterative_core_pkg;

  localparam int unsigned ZLEN  = 62;
  localparam int unsigned MAXW  = 64;

  typedef enum logic [2:0] {
    ST_NOKEY  = 3'd0,
    ST_EXPAND = 3'd1,
    ST_READY  = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Sequences written first-element-leftmost, so element i lives at bit 61-i.
  function automatic logic [ZLEN-1:0] z_const(input int unsigned sel);
    logic [ZLEN-1:0] z;
    case (sel)
      1:       z = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       z = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       z = 62'b11011011101011000110010111100000010010001010011100110100001111;
      4:       z = 62'b11010001111001101011011000100000010111000011001010010011101111;
      default: z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    endcase
    return z;
  endfunction

  function automatic logic z_bit(input int unsigned sel, input logic [5:0] idx);
    logic [ZLEN-1:0] z;
    z = z_const(sel);
    return z[6'd61 - idx];
  endfunction

  function automatic logic [MAXW-1:0] word_mask(input int unsigned w);
    return (w >= MAXW) ? {MAXW{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Rotate left by s within a w-bit word held in the low bits of v.
  function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] v,
                                           input int unsigned s,
                                           input int unsigned w);
    logic [MAXW-1:0] a;
    int unsigned     sh;
    a  = v & word_mask(w);
    sh = s % w;
    if (sh == 0) return a;
    return ((a << sh) | (a >> (w - sh))) & word_mask(w);
  endfunction

  function automatic logic [MAXW-1:0] rotr(input logic [MAXW-1:0] v,
                                           input int unsigned s,
                                           input int unsigned w);
    return rotl(v, (w - (s % w)) % w, w);
  endfunction

  // Simon round nonlinearity f(x) = (x<<<1 & x<<<8) ^ x<<<2.
  function automatic logic [MAXW-1:0] round_f(input logic [MAXW-1:0] x,
                                              input int unsigned w);
    return (rotl(x, 1, w) & rotl(x, 8, w)) ^ rotl(x, 2, w);
  endfunction

endpackage

// File: rtl/simon_iterative_core_if.sv
// Handshake bundle for the Simon engine: key load, input block and output block
// channels, each valid/ready.
//   master : drives key/key_valid, in_block/in_decrypt/in_valid, out_ready
//   slave  : drives key_ready, in_ready, out_block/out_valid
interface simon_iterative_core_if #(
  parameter int unsigned WORD      = 16,
  parameter int unsigned KEY_WORDS = 4
);
  logic [KEY_WORDS*WORD-1:0] key;
  logic                      key_valid;
  logic                      key_ready;
  logic [2*WORD-1:0]         in_block;
  logic                      in_decrypt;
  logic                      in_valid;
  logic                      in_ready;
  logic [2*WORD-1:0]         out_block;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output key, key_valid, in_block, in_decrypt, in_valid, out_ready,
    input  key_ready, in_ready, out_block, out_valid
  );

  modport slave (
    input  key, key_valid, in_block, in_decrypt, in_valid, out_ready,
    output key_ready, in_ready, out_block, out_valid
  );
endinterface

// File: rtl/simon_iterative_core_key_expand.sv
// Simon subkey register file plus the one-subkey-per-cycle expansion generator.
//   clk, rst_n    : clock, async active-low reset (clears the whole file)
//   load_i        : write key words k0..k(m-1) into entries 0..m-1, restart generator
//   key_i         : key, word i at [i*WORD +: WORD]
//   exp_en_i      : produce subkey idx+m this cycle
//   exp_last_c_o  : current expansion step is the final one
//   rd_idx_i      : round-key read index
//   rd_data_c_o   : subkey at rd_idx_i
module simon_iterative_core_key_expand
  import simon_iterative_core_pkg::*;
#(
  parameter  int unsigned WORD      = 16,
  parameter  int unsigned KEY_WORDS = 4,
  parameter  int unsigned ROUNDS    = 32,
  parameter  int unsigned Z_IDX     = 0,
  localparam int unsigned IW        = $clog2(ROUNDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [KEY_WORDS*WORD-1:0] key_i,
  input  logic                      exp_en_i,
  output logic                      exp_last_c_o,
  input  logic [IW-1:0]             rd_idx_i,
  output logic [WORD-1:0]           rd_data_c_o
);

  localparam int unsigned NEXP = ROUNDS - KEY_WORDS;

  logic [WORD-1:0] file_q [ROUNDS];
  logic [IW-1:0]   idx_q;
  logic [5:0]      zi_q;

  logic [WORD-1:0] k_lo, k_nx, k_hi, tmp_c, new_c;
  logic [IW-1:0]   wr_idx;

  // Next subkey from k[i], k[i+1], k[i+m-1]; z bit from a separate mod-62 counter.
  always_comb begin
    k_lo   = file_q[idx_q];
    k_nx   = file_q[idx_q + IW'(1)];
    k_hi   = file_q[idx_q + IW'(KEY_WORDS - 1)];
    tmp_c  = WORD'(rotr(64'(k_hi), 3, WORD));
    if (KEY_WORDS == 4) tmp_c = tmp_c ^ k_nx;
    new_c  = ~k_lo ^ tmp_c ^ WORD'(rotr(64'(tmp_c), 1, WORD))
           ^ WORD'(z_bit(Z_IDX, zi_q)) ^ WORD'(3);
    wr_idx = idx_q + IW'(KEY_WORDS);
  end

  assign exp_last_c_o = (idx_q == IW'(NEXP - 1));
  assign rd_data_c_o  = file_q[rd_idx_i];

  // Register file and generator counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < ROUNDS; j++) file_q[j] <= '0;
      idx_q <= '0;
      zi_q  <= '0;
    end else if (load_i) begin
      for (int j = 0; j < KEY_WORDS; j++) file_q[j] <= key_i[j*WORD +: WORD];
      idx_q <= '0;
      zi_q  <= '0;
    end else if (exp_en_i) begin
      file_q[wr_idx] <= new_c;
      idx_q          <= idx_q + IW'(1);
      zi_q           <= (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
    end
  end

endmodule

// File: rtl/simon_iterative_core.sv
// Iterative Simon block cipher engine, one round per clock, encrypt or decrypt.
// A key is expanded once into the subkey file; blocks then reuse it until a new
// key is accepted in NOKEY/READY.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of simon_iterative_core_if (key, input and output channels)
// Decryption runs the encryption round with reversed subkeys on swapped halves,
// swapping back on output.
module simon_iterative_core
  import simon_iterative_core_pkg::*;
#(
  parameter int unsigned WORD      = 16,
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned ROUNDS    = 32,
  parameter int unsigned Z_IDX     = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  simon_iterative_core_if.slave bus
);

  localparam int unsigned IW = $clog2(ROUNDS);
  localparam int unsigned BW = 2 * WORD;

  state_e          state_q, state_d;
  logic [WORD-1:0] x_q, x_d, y_q, y_d;
  logic            dec_q, dec_d;
  logic [IW-1:0]   r_q, r_d;
  logic [BW-1:0]   ob_q, ob_d;
  logic            key_rdy_q, key_rdy_d;
  logic            in_rdy_q, in_rdy_d;
  logic            ov_q, ov_d;

  logic            load_c, exp_en_c, exp_last_c;
  logic            key_take_c, blk_take_c;
  logic [IW-1:0]   rd_idx_c;
  logic [WORD-1:0] rk_c, fx_c;

  simon_iterative_core_key_expand #(
    .WORD      (WORD),
    .KEY_WORDS (KEY_WORDS),
    .ROUNDS    (ROUNDS),
    .Z_IDX     (Z_IDX)
  ) u_key_expand (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_c),
    .key_i        (bus.key),
    .exp_en_i     (exp_en_c),
    .exp_last_c_o (exp_last_c),
    .rd_idx_i     (rd_idx_c),
    .rd_data_c_o  (rk_c)
  );

  // A key offer in READY blocks the input channel in the same cycle.
  assign bus.key_ready = key_rdy_q;
  assign bus.in_ready  = in_rdy_q & ~bus.key_valid;
  assign bus.out_valid = ov_q;
  assign bus.out_block = ob_q;

  assign key_take_c = bus.key_valid & key_rdy_q;
  assign blk_take_c = bus.in_valid & in_rdy_q & ~bus.key_valid;
  assign rd_idx_c   = dec_q ? (IW'(ROUNDS - 1) - r_q) : r_q;
  assign fx_c       = WORD'(round_f(64'(x_q), WORD));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dec_d    = dec_q;
    r_d      = r_q;
    ob_d     = ob_q;
    load_c   = 1'b0;
    exp_en_c = 1'b0;

    unique case (state_q)
      ST_NOKEY: begin
        if (key_take_c) begin
          load_c  = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        exp_en_c = 1'b1;
        if (exp_last_c) state_d = ST_READY;
      end
      ST_READY: begin
        if (key_take_c) begin
          load_c  = 1'b1;
          state_d = ST_EXPAND;
        end else if (blk_take_c) begin
          dec_d   = bus.in_decrypt;
          x_d     = bus.in_decrypt ? bus.in_block[WORD-1:0]  : bus.in_block[BW-1:WORD];
          y_d     = bus.in_decrypt ? bus.in_block[BW-1:WORD] : bus.in_block[WORD-1:0];
          r_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        x_d = y_q ^ fx_c ^ rk_c;
        y_d = x_q;
        r_d = r_q + IW'(1);
        if (r_q == IW'(ROUNDS - 1)) begin
          ob_d    = dec_q ? {y_d, x_d} : {x_d, y_d};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_READY;
      end
      default: state_d = ST_NOKEY;
    endcase

    key_rdy_d = (state_d == ST_NOKEY) || (state_d == ST_READY);
    in_rdy_d  = (state_d == ST_READY);
    ov_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_NOKEY;
      x_q       <= '0;
      y_q       <= '0;
      dec_q     <= 1'b0;
      r_q       <= '0;
      ob_q      <= '0;
      key_rdy_q <= 1'b0;
      in_rdy_q  <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dec_q     <= dec_d;
      r_q       <= r_d;
      ob_q      <= ob_d;
      key_rdy_q <= key_rdy_d;
      in_rdy_q  <= in_rdy_d;
      ov_q      <= ov_d;
    end
  end

endmodule

// File: tb/tb_simon_iterative_core.sv
// Bench for simon_iterative_core: a Simon32/64 instance and a Simon64/128 instance.
// Expected results come from a plain-arithmetic Simon model (real inverse rounds for
// decryption) plus published test vectors.
`timescale 1ns/1ps
module tb_simon_iterative_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  simon_iterative_core_if #(.WORD(16), .KEY_WORDS(4)) b16();
  simon_iterative_core_if #(.WORD(32), .KEY_WORDS(4)) b32();

  simon_iterative_core #(.WORD(16), .KEY_WORDS(4), .ROUNDS(32), .Z_IDX(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(b16.slave));
  simon_iterative_core #(.WORD(32), .KEY_WORDS(4), .ROUNDS(44), .Z_IDX(3)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32.slave));

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] exp16 = '0, exp32 = '0;
  logic        exp16_v = 1'b0, exp32_v = 1'b0;

  localparam logic [61:0] ZT [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111};

  // ---------------- reference model ----------------
  function automatic logic [63:0] msk(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] m_rotl(input logic [63:0] v, input int unsigned s,
                                         input int unsigned w);
    logic [63:0] a;
    int unsigned sh;
    a  = v & msk(w);
    sh = s % w;
    if (sh == 0) return a;
    return ((a << sh) | (a >> (w - sh))) & msk(w);
  endfunction

  function automatic logic [63:0] m_rotr(input logic [63:0] v, input int unsigned s,
                                         input int unsigned w);
    return m_rotl(v, (w - (s % w)) % w, w);
  endfunction

  function automatic logic [63:0] m_f(input logic [63:0] x, input int unsigned w);
    return (m_rotl(x, 1, w) & m_rotl(x, 8, w)) ^ m_rotl(x, 2, w);
  endfunction

  function automatic logic [63:0] simon_model(input logic [127:0] key, input logic [63:0] blk,
                                              input bit dec, input int unsigned w,
                                              input int unsigned m, input int unsigned t,
                                              input int unsigned zi);
    logic [63:0] k [128];
    logic [63:0] x, y, tmp, mk;
    logic [61:0] zs;
    mk = msk(w);
    zs = ZT[zi];
    for (int i = 0; i < int'(m); i++) k[i] = 64'(key >> (i * int'(w))) & mk;
    for (int i = int'(m); i < int'(t); i++) begin
      tmp = m_rotr(k[i-1], 3, w);
      if (m == 4) tmp = tmp ^ k[i-3];
      k[i] = (~k[i-int'(m)] & mk) ^ tmp ^ m_rotr(tmp, 1, w)
           ^ 64'(zs[61 - ((i - int'(m)) % 62)]) ^ 64'd3;
    end
    x = (blk >> w) & mk;
    y = blk & mk;
    if (!dec) begin
      for (int r = 0; r < int'(t); r++) begin
        tmp = x; x = y ^ m_f(x, w) ^ k[r]; y = tmp;
      end
    end else begin
      for (int r = int'(t) - 1; r >= 0; r--) begin
        tmp = y; y = x ^ m_f(y, w) ^ k[r]; x = tmp;
      end
    end
    return (x << w) | y;
  endfunction

  function automatic logic [63:0] model16(input logic [63:0] key, input logic [63:0] blk,
                                          input bit dec);
    return simon_model(128'(key), blk, dec, 16, 4, 32, 0);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: whenever a result is presented it must be the expected one,
  // and the input channel must be closed.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b16.out_valid === 1'b1) begin
        chk("out16_expected_pending", 64'(exp16_v), 64'd1);
        chk("out16_block", 64'(b16.out_block), exp16);
        chk("out16_in_ready_low", 64'(b16.in_ready), 64'd0);
      end
      if (b32.out_valid === 1'b1) begin
        chk("out32_expected_pending", 64'(exp32_v), 64'd1);
        chk("out32_block", 64'(b32.out_block), exp32);
        chk("out32_in_ready_low", 64'(b32.in_ready), 64'd0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic kr(input bit s);
    return s ? b32.key_ready : b16.key_ready;
  endfunction
  function automatic logic ir(input bit s);
    return s ? b32.in_ready : b16.in_ready;
  endfunction
  function automatic logic ov(input bit s);
    return s ? b32.out_valid : b16.out_valid;
  endfunction

  task automatic load_key(input bit s, input logic [127:0] k);
    logic rdy;
    int   n;
    n = 0;
    if (s) begin b32.key = k; b32.key_valid = 1'b1; end
    else begin b16.key = k[63:0]; b16.key_valid = 1'b1; end
    do begin
      rdy = kr(s);
      tick();
      n++;
    end while (!rdy && n < 200);
    b16.key_valid = 1'b0;
    b32.key_valid = 1'b0;
    if (!rdy) chk("key_accept_timeout", 64'(n), 64'd0);
  endtask

  task automatic wait_key_ready(input bit s, output int n);
    n = 0;
    while (!kr(s) && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Offer a block; returns edges until accepted (1 = accepted on first edge).
  task automatic send_block(input bit s, input logic [63:0] blk, input bit dec,
                            input logic [63:0] expect_out, output int n);
    logic rdy;
    n = 0;
    if (s) begin b32.in_block = blk; b32.in_decrypt = dec; b32.in_valid = 1'b1; end
    else begin b16.in_block = blk[31:0]; b16.in_decrypt = dec; b16.in_valid = 1'b1; end
    do begin
      rdy = ir(s);
      tick();
      n++;
    end while (!rdy && n < 200);
    b16.in_valid = 1'b0;
    b32.in_valid = 1'b0;
    if (s) begin exp32 = expect_out; exp32_v = 1'b1; end
    else begin exp16 = expect_out; exp16_v = 1'b1; end
  endtask

  task automatic wait_result(input bit s, output int lat, output logic [63:0] blk);
    lat = 0;
    while (!ov(s) && lat < 200) begin
      tick();
      lat++;
    end
    blk = s ? b32.out_block : 64'(b16.out_block);
  endtask

  task automatic consume(input bit s);
    if (s) b32.out_ready = 1'b1; else b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
    b32.out_ready = 1'b0;
    if (s) exp32_v = 1'b0; else exp16_v = 1'b0;
    chk(s ? "out32_valid_drop" : "out16_valid_drop", 64'(ov(s)), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0]  K1  = 64'h1918_1110_0908_0100;
  localparam logic [63:0]  K2  = 64'h0f1e_2d3c_4b5a_6978;
  localparam logic [63:0]  PT1 = 64'h6565_6877;
  localparam logic [63:0]  CT1 = 64'hc69b_e9bb;
  localparam logic [127:0] K3  = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT3 = 64'h656b696c_20646e75;
  localparam logic [63:0]  CT3 = 64'h44c8fc20_b9dfa07a;

  initial begin
    int          n, lat;
    logic [63:0] blk, got;

    rst_n = 1'b0;
    b16.key = '0; b16.key_valid = 0; b16.in_block = '0; b16.in_decrypt = 0;
    b16.in_valid = 0; b16.out_ready = 0;
    b32.key = '0; b32.key_valid = 0; b32.in_block = '0; b32.in_decrypt = 0;
    b32.in_valid = 0; b32.out_ready = 0;

    // model pinned to published vectors
    chk("model_pin_enc16", model16(K1, PT1, 1'b0), CT1);
    chk("model_pin_dec16", model16(K1, CT1, 1'b1), PT1);
    chk("model_pin_enc32", simon_model(K3, PT3, 1'b0, 32, 4, 44, 3), CT3);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", 64'(b16.key_ready), 64'd0);
    chk("rst_in_ready",  64'(b16.in_ready),  64'd0);
    chk("rst_out_valid", 64'(b16.out_valid), 64'd0);
    chk("rst_out_block", 64'(b16.out_block), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("nokey_in_ready", 64'(b16.in_ready), 64'd0);

    // Simon32/64 key, expansion length, reference encrypt/decrypt
    load_key(1'b0, 128'(K1));
    wait_key_ready(1'b0, n);
    chk("expand_cycles16", 64'(n), 64'd28);
    chk("ready_in_ready16", 64'(b16.in_ready), 64'd1);

    send_block(1'b0, PT1, 1'b0, CT1, n);
    chk("accept16_first_edge", 64'(n), 64'd1);
    wait_result(1'b0, lat, got);
    chk("latency16_enc", 64'(lat), 64'd32);
    chk("ct16_vector", got, CT1);
    consume(1'b0);
    chk("key_reuse_key_ready", 64'(b16.key_ready), 64'd1);
    chk("key_reuse_in_ready",  64'(b16.in_ready),  64'd1);

    send_block(1'b0, CT1, 1'b1, PT1, n);
    wait_result(1'b0, lat, got);
    chk("latency16_dec", 64'(lat), 64'd32);
    chk("pt16_vector", got, PT1);
    consume(1'b0);

    // assorted blocks, alternating direction
    for (int i = 0; i < 4; i++) begin
      blk = 64'($urandom);
      send_block(1'b0, blk, i[0], model16(K1, blk, i[0]), n);
      chk("accept16_back_to_back", 64'(n), 64'd1);
      wait_result(1'b0, lat, got);
      chk("latency16_mix", 64'(lat), 64'd32);
      consume(1'b0);
    end

    // hold result 10 cycles with a key offered: result stable, key ignored
    blk = 64'h1234_abcd;
    send_block(1'b0, blk, 1'b0, model16(K1, blk, 1'b0), n);
    wait_result(1'b0, lat, got);
    b16.key = K2;
    b16.key_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_out_valid", 64'(b16.out_valid), 64'd1);
      chk("hold_key_ready", 64'(b16.key_ready), 64'd0);
    end
    chk("hold_block", 64'(b16.out_block), model16(K1, blk, 1'b0));
    b16.key_valid = 1'b0;
    consume(1'b0);
    chk("hold_no_expand_in_ready", 64'(b16.in_ready), 64'd1);
    blk = 64'h0bad_f00d;
    send_block(1'b0, blk, 1'b0, model16(K1, blk, 1'b0), n);
    chk("hold_old_key_accept", 64'(n), 64'd1);
    wait_result(1'b0, lat, got);
    consume(1'b0);

    // key and block offered together: key wins, block waits for expansion
    b16.key = K2;
    b16.key_valid = 1'b1;
    b16.in_block = 32'h5a5a_c3c3;
    b16.in_decrypt = 1'b0;
    b16.in_valid = 1'b1;
    #1;
    chk("prio_in_ready_forced_low", 64'(b16.in_ready), 64'd0);
    tick();
    b16.key_valid = 1'b0;
    chk("prio_key_taken", 64'(b16.key_ready), 64'd0);
    send_block(1'b0, 64'h5a5a_c3c3, 1'b0, model16(K2, 64'h5a5a_c3c3, 1'b0), n);
    chk("prio_block_wait_edges", 64'(n), 64'd29);
    wait_result(1'b0, lat, got);
    chk("prio_latency", 64'(lat), 64'd32);
    consume(1'b0);

    // Simon64/128 instance
    load_key(1'b1, K3);
    wait_key_ready(1'b1, n);
    chk("expand_cycles32", 64'(n), 64'd40);
    send_block(1'b1, PT3, 1'b0, CT3, n);
    wait_result(1'b1, lat, got);
    chk("latency32_enc", 64'(lat), 64'd44);
    chk("ct32_vector", got, CT3);
    consume(1'b1);
    send_block(1'b1, CT3, 1'b1, PT3, n);
    wait_result(1'b1, lat, got);
    chk("pt32_vector", got, PT3);
    consume(1'b1);

    // reset at round 10 of a running block
    blk = 64'h7777_1111;
    send_block(1'b0, blk, 1'b0, model16(K2, blk, 1'b0), n);
    repeat (10) tick();
    rst_n = 1'b0;
    exp16_v = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 64'(b16.out_valid), 64'd0);
    chk("midrun_rst_out_block", 64'(b16.out_block), 64'd0);
    chk("midrun_rst_key_ready", 64'(b16.key_ready), 64'd0);
    chk("midrun_rst_in_ready",  64'(b16.in_ready),  64'd0);
    #2;
    rst_n = 1'b1;
    b16.in_block = 32'h2222_3333;
    b16.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_in_ready", 64'(b16.in_ready), 64'd0);
    end
    b16.in_valid = 1'b0;
    load_key(1'b0, 128'(K1));
    wait_key_ready(1'b0, n);
    chk("post_rst_expand_cycles", 64'(n), 64'd28);
    send_block(1'b0, PT1, 1'b0, CT1, n);
    wait_result(1'b0, lat, got);
    chk("post_rst_ct16", got, CT1);
    consume(1'b0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
